// File: rtl/cpu_trace_parser_if.sv
// Character stream in, decoded trace-line report out.
// master = stream source / report consumer; slave = the parser.
interface cpu_trace_parser_if #(
  parameter int HW = 32
);
  logic [7:0]    char;
  logic [1:0]    format_type;
  logic [31:0]   time_val;
  logic [HW-1:0] pc_val;
  logic [HW-1:0] idx_val;
  logic [HW-1:0] data_val;
  logic [15:0]   ok_count;
  logic [15:0]   err_count;

  modport master (
    output char,
    input  format_type, time_val, pc_val, idx_val, data_val, ok_count, err_count
  );

  modport slave (
    input  char,
    output format_type, time_val, pc_val, idx_val, data_val, ok_count, err_count
  );
endinterface

// File: rtl/cpu_trace_parser.sv
// Character-serial parser for CPU trace lines (register / memory writes).
// Extracts time, pc, grf/addr and data fields, flags semantic errors, counts lines.
module cpu_trace_parser #(
  parameter int          TIME_DIGITS = 4,
  parameter int          GRF_DIGITS  = 4,
  parameter int          HEX_DIGITS  = 8,
  parameter int          ALLOW_UPPER = 0,
  parameter int          CHECK_SEM   = 1,
  parameter logic [31:0] PC_MIN      = 32'h0000_3000,
  parameter logic [31:0] PC_MAX      = 32'h0000_6ffc
) (
  input  logic              clk,
  input  logic              reset,
  cpu_trace_parser_if.slave bus
);
  localparam int HW = 4 * HEX_DIGITS;

  localparam logic [4:0] S_IDLE   = 5'd0;
  localparam logic [4:0] S_CARET  = 5'd1;
  localparam logic [4:0] S_TIME   = 5'd2;
  localparam logic [4:0] S_AT     = 5'd3;
  localparam logic [4:0] S_PC     = 5'd4;
  localparam logic [4:0] S_COLON  = 5'd5;
  localparam logic [4:0] S_SP1    = 5'd6;
  localparam logic [4:0] S_STAR   = 5'd7;
  localparam logic [4:0] S_ADDR   = 5'd8;
  localparam logic [4:0] S_ASP    = 5'd9;
  localparam logic [4:0] S_DOLLAR = 5'd10;
  localparam logic [4:0] S_GRF    = 5'd11;
  localparam logic [4:0] S_GSP    = 5'd12;
  localparam logic [4:0] S_LT     = 5'd13;
  localparam logic [4:0] S_EQ     = 5'd14;
  localparam logic [4:0] S_DATA   = 5'd15;
  localparam logic [4:0] S_HASH_R = 5'd16;
  localparam logic [4:0] S_HASH_M = 5'd17;
  localparam logic [4:0] S_ACC    = 5'd18;

  localparam logic [7:0]    TD        = 8'(TIME_DIGITS);
  localparam logic [7:0]    GD        = 8'(GRF_DIGITS);
  localparam logic [7:0]    HD        = 8'(HEX_DIGITS);
  localparam logic [HW-1:0] PC_MIN_HW = HW'(PC_MIN);
  localparam logic [HW-1:0] PC_MAX_HW = HW'(PC_MAX);
  localparam logic [HW-1:0] GRF_MAX   = HW'(31);

  logic [4:0]    state_reg, state_next;
  logic [7:0]    cnt_reg, cnt_next, cnt_inc;
  logic [31:0]   time_acc_reg, time_next, time_dec;
  logic [HW-1:0] pc_acc_reg, pc_next, pc_hex;
  logic [HW-1:0] idx_acc_reg, idx_next, idx_dec, idx_hex;
  logic [HW-1:0] data_acc_reg, data_next, data_hex;
  logic          is_mem_reg, is_mem_next;
  logic          accept, sem_err;
  logic [1:0]    line_type;

  logic [1:0]    format_type_reg;
  logic [31:0]   time_val_reg;
  logic [HW-1:0] pc_val_reg, idx_val_reg, data_val_reg;
  logic [15:0]   ok_count_reg, err_count_reg;

  logic [7:0] ch;
  logic       is_dec, is_lower, is_upper, is_hex;
  logic [3:0] nib;

  assign ch       = bus.char;
  assign is_dec   = (ch >= "0") && (ch <= "9");
  assign is_lower = (ch >= "a") && (ch <= "f");
  assign is_upper = (ALLOW_UPPER != 0) && (ch >= "A") && (ch <= "F");
  assign is_hex   = is_dec || is_lower || is_upper;
  // 'a'/'A' have low nibble 1, so letters map to low nibble + 9
  assign nib      = is_dec ? ch[3:0] : (ch[3:0] + 4'd9);

  assign cnt_inc  = cnt_reg + 8'd1;
  assign time_dec = (time_acc_reg * 32'd10) + {28'd0, ch[3:0]};
  assign idx_dec  = (idx_acc_reg * HW'(10)) + HW'(ch[3:0]);
  assign pc_hex   = (pc_acc_reg << 4) | HW'(nib);
  assign idx_hex  = (idx_acc_reg << 4) | HW'(nib);
  assign data_hex = (data_acc_reg << 4) | HW'(nib);

  always_comb begin
    state_next  = S_IDLE;
    cnt_next    = cnt_reg;
    time_next   = time_acc_reg;
    pc_next     = pc_acc_reg;
    idx_next    = idx_acc_reg;
    data_next   = data_acc_reg;
    is_mem_next = is_mem_reg;
    accept      = 1'b0;
    if (ch == "^") begin
      state_next  = S_CARET;
      cnt_next    = '0;
      time_next   = '0;
      pc_next     = '0;
      idx_next    = '0;
      data_next   = '0;
      is_mem_next = 1'b0;
    end else begin
      case (state_reg)
        S_CARET: begin
          if (is_dec) begin
            state_next = S_TIME;
            cnt_next   = 8'd1;
            time_next  = time_dec;
          end
        end
        S_TIME: begin
          if (is_dec && (cnt_reg < TD)) begin
            state_next = S_TIME;
            cnt_next   = cnt_inc;
            time_next  = time_dec;
          end else if (ch == "@") begin
            state_next = S_AT;
            cnt_next   = '0;
          end
        end
        S_AT, S_PC: begin
          if (is_hex && (cnt_reg < HD)) begin
            state_next = S_PC;
            cnt_next   = cnt_inc;
            pc_next    = pc_hex;
          end else if ((ch == ":") && (cnt_reg == HD)) begin
            state_next = S_COLON;
          end
        end
        S_COLON, S_SP1: begin
          if (ch == " ") begin
            state_next = S_SP1;
          end else if (ch == "*") begin
            state_next  = S_STAR;
            cnt_next    = '0;
            is_mem_next = 1'b1;
          end else if (ch == "$") begin
            state_next  = S_DOLLAR;
            cnt_next    = '0;
            is_mem_next = 1'b0;
          end
        end
        S_STAR, S_ADDR: begin
          if (is_hex && (cnt_reg < HD)) begin
            state_next = S_ADDR;
            cnt_next   = cnt_inc;
            idx_next   = idx_hex;
          end else if ((cnt_reg == HD) && (ch == " ")) begin
            state_next = S_ASP;
          end else if ((cnt_reg == HD) && (ch == "<")) begin
            state_next = S_LT;
          end
        end
        S_DOLLAR, S_GRF: begin
          if (is_dec && (cnt_reg < GD)) begin
            state_next = S_GRF;
            cnt_next   = cnt_inc;
            idx_next   = idx_dec;
          end else if ((state_reg == S_GRF) && (ch == " ")) begin
            state_next = S_GSP;
          end else if ((state_reg == S_GRF) && (ch == "<")) begin
            state_next = S_LT;
          end
        end
        S_ASP, S_GSP: begin
          if (ch == " ") state_next = state_reg;
          else if (ch == "<") state_next = S_LT;
        end
        S_LT: begin
          if (ch == "=") begin
            state_next = S_EQ;
            cnt_next   = '0;
          end
        end
        S_EQ, S_DATA: begin
          if ((state_reg == S_EQ) && (ch == " ")) begin
            state_next = S_EQ;
          end else if (is_hex) begin
            cnt_next   = cnt_inc;
            data_next  = data_hex;
            // the final data digit already selects the terminator state, which carries the line type
            if (cnt_inc != HD) state_next = S_DATA;
            else               state_next = is_mem_reg ? S_HASH_M : S_HASH_R;
          end
        end
        S_HASH_R, S_HASH_M: begin
          if (ch == "#") begin
            state_next = S_ACC;
            accept     = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sem_err = 1'b0;
    if (CHECK_SEM != 0) begin
      if ((pc_acc_reg < PC_MIN_HW) || (pc_acc_reg > PC_MAX_HW) || (pc_acc_reg[1:0] != 2'b00))
        sem_err = 1'b1;
      if (state_reg == S_HASH_M) begin
        if (idx_acc_reg[1:0] != 2'b00) sem_err = 1'b1;
      end else if (idx_acc_reg > GRF_MAX) begin
        sem_err = 1'b1;
      end
    end
  end

  assign line_type = sem_err ? 2'b11 : ((state_reg == S_HASH_M) ? 2'b10 : 2'b01);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      time_acc_reg    <= '0;
      pc_acc_reg      <= '0;
      idx_acc_reg     <= '0;
      data_acc_reg    <= '0;
      is_mem_reg      <= 1'b0;
      format_type_reg <= 2'b00;
      time_val_reg    <= '0;
      pc_val_reg      <= '0;
      idx_val_reg     <= '0;
      data_val_reg    <= '0;
      ok_count_reg    <= '0;
      err_count_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      time_acc_reg    <= time_next;
      pc_acc_reg      <= pc_next;
      idx_acc_reg     <= idx_next;
      data_acc_reg    <= data_next;
      is_mem_reg      <= is_mem_next;
      format_type_reg <= accept ? line_type : 2'b00;
      if (accept) begin
        time_val_reg <= time_acc_reg;
        pc_val_reg   <= pc_acc_reg;
        idx_val_reg  <= idx_acc_reg;
        data_val_reg <= data_acc_reg;
        if (sem_err) begin
          if (err_count_reg != 16'hFFFF) err_count_reg <= err_count_reg + 16'd1;
        end else begin
          if (ok_count_reg != 16'hFFFF) ok_count_reg <= ok_count_reg + 16'd1;
        end
      end
    end
  end

  assign bus.format_type = format_type_reg;
  assign bus.time_val    = time_val_reg;
  assign bus.pc_val      = pc_val_reg;
  assign bus.idx_val     = idx_val_reg;
  assign bus.data_val    = data_val_reg;
  assign bus.ok_count    = ok_count_reg;
  assign bus.err_count   = err_count_reg;
endmodule

// File: tb/tb_cpu_trace_parser.sv
// Bench for cpu_trace_parser: default instance plus a CHECK_SEM=0 / ALLOW_UPPER=1 instance
// fed the same character stream; reports are checked against a cycle-stamped scoreboard.
module tb_cpu_trace_parser;
  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ch    = 8'h2e;
  int         cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_trace_parser_if #(.HW(32)) bus_a ();
  cpu_trace_parser_if #(.HW(32)) bus_b ();
  assign bus_a.char = ch;
  assign bus_b.char = ch;

  cpu_trace_parser #(.HEX_DIGITS(8)) dut (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  cpu_trace_parser #(.HEX_DIGITS(8), .ALLOW_UPPER(1), .CHECK_SEM(0)) dut_alt (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  typedef struct {
    string       line;
    logic [1:0]  ft_a;
    logic [1:0]  ft_b;
    logic [31:0] t;
    logic [31:0] pc;
    logic [31:0] idx;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic [1:0]  ft_a;
    logic [1:0]  ft_b;
    logic [31:0] t;
    logic [31:0] pc;
    logic [31:0] idx;
    logic [31:0] data;
    logic [15:0] ok_a;
    logic [15:0] err_a;
    logic [15:0] ok_b;
    logic [15:0] err_b;
    int          due;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] exp_ok_a = 0, exp_err_a = 0, exp_ok_b = 0, exp_err_b = 0;
  logic [31:0] last_t = 0, last_pc = 0, last_idx = 0, last_data = 0;

  function automatic vec_t mk(string l, logic [1:0] fa, logic [1:0] fb,
                              logic [31:0] t, logic [31:0] pc, logic [31:0] idx, logic [31:0] d);
    vec_t v;
    v.line = l; v.ft_a = fa; v.ft_b = fb; v.t = t; v.pc = pc; v.idx = idx; v.data = d;
    return v;
  endfunction

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_expect(input vec_t v);
    exp_t e;
    if (v.ft_a == 2'b11) exp_err_a = sat_inc(exp_err_a);
    else if (v.ft_a != 2'b00) exp_ok_a = sat_inc(exp_ok_a);
    if (v.ft_b == 2'b11) exp_err_b = sat_inc(exp_err_b);
    else if (v.ft_b != 2'b00) exp_ok_b = sat_inc(exp_ok_b);
    if (v.ft_a != 2'b00) begin
      last_t = v.t; last_pc = v.pc; last_idx = v.idx; last_data = v.data;
    end
    e.ft_a = v.ft_a; e.ft_b = v.ft_b; e.t = v.t; e.pc = v.pc; e.idx = v.idx; e.data = v.data;
    e.ok_a = exp_ok_a; e.err_a = exp_err_a; e.ok_b = exp_ok_b; e.err_b = exp_err_b;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic send_line(input vec_t v);
    for (int i = 0; i < v.line.len(); i++) begin
      @(negedge clk);
      ch = v.line[i];
      if ((i == v.line.len() - 1) && ((v.ft_a != 2'b00) || (v.ft_b != 2'b00)))
        push_expect(v);
    end
    $display("tx \"%s\" expect a=%b b=%b", v.line, v.ft_a, v.ft_b);
  endtask

  task automatic send_raw(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      ch = s[i];
    end
    $display("tx raw \"%s\"", s);
  endtask

  // Monitor: a report must appear exactly on the due cycle and nowhere else.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((sb.size() > 0) && (sb[0].due == cyc)) begin
        e = sb.pop_front();
        chk("ft_a", 32'(bus_a.format_type), 32'(e.ft_a));
        chk("ft_b", 32'(bus_b.format_type), 32'(e.ft_b));
        if (e.ft_a != 2'b00) begin
          chk("time_a", bus_a.time_val, e.t);
          chk("pc_a",   bus_a.pc_val,   e.pc);
          chk("idx_a",  bus_a.idx_val,  e.idx);
          chk("data_a", bus_a.data_val, e.data);
        end
        if (e.ft_b != 2'b00) begin
          chk("time_b", bus_b.time_val, e.t);
          chk("idx_b",  bus_b.idx_val,  e.idx);
          chk("data_b", bus_b.data_val, e.data);
        end
        chk("ok_a",  32'(bus_a.ok_count),  32'(e.ok_a));
        chk("err_a", 32'(bus_a.err_count), 32'(e.err_a));
        chk("ok_b",  32'(bus_b.ok_count),  32'(e.ok_b));
        chk("err_b", 32'(bus_b.err_count), 32'(e.err_b));
      end else if ((bus_a.format_type != 2'b00) || (bus_b.format_type != 2'b00)) begin
        chk("spurious_report", {28'd0, bus_a.format_type, bus_b.format_type}, 32'd0);
      end
    end
  end

  initial begin
    vecs.push_back(mk("^12@00003010: $3 <= 0000abcd#", 2'b01, 2'b01, 32'd12, 32'h3010, 32'd3, 32'h0000abcd));
    vecs.push_back(mk("^7@00003004:   *00000010  <=  deadbeef#", 2'b10, 2'b10, 32'd7, 32'h3004, 32'h10, 32'hdeadbeef));
    vecs.push_back(mk("^7@00003004:   *00000011  <=  deadbeef#", 2'b11, 2'b10, 32'd7, 32'h3004, 32'h11, 32'hdeadbeef));
    vecs.push_back(mk("^1@00002ffc: $1 <= 00000000#", 2'b11, 2'b01, 32'd1, 32'h2ffc, 32'd1, 32'h0));
    vecs.push_back(mk("^5@00003000: $32 <= 00000001#", 2'b11, 2'b01, 32'd5, 32'h3000, 32'd32, 32'h1));
    vecs.push_back(mk("^0042@00006ffc: $0031 <= 12345678#", 2'b01, 2'b01, 32'd42, 32'h6ffc, 32'd31, 32'h12345678));
    vecs.push_back(mk("^9@00007000: *00000100 <= 00000000#", 2'b11, 2'b10, 32'd9, 32'h7000, 32'h100, 32'h0));
    vecs.push_back(mk("^9@00003002: $1 <= 00000000#", 2'b11, 2'b01, 32'd9, 32'h3002, 32'd1, 32'h0));
    vecs.push_back(mk("^9999@00003000:*00000004<=00000005#", 2'b10, 2'b10, 32'd9999, 32'h3000, 32'h4, 32'h5));
    vecs.push_back(mk("^99@0000^2@00003000: $4 <= 00000004#", 2'b01, 2'b01, 32'd2, 32'h3000, 32'd4, 32'h4));
    vecs.push_back(mk("xx#^3@00003000: $2 <= 00000002#", 2'b01, 2'b01, 32'd3, 32'h3000, 32'd2, 32'h2));
    vecs.push_back(mk("^1@00003000: $1 <= 0000ABCD#", 2'b00, 2'b01, 32'd1, 32'h3000, 32'd1, 32'h0000abcd));
    vecs.push_back(mk("^12345@00003000: $1 <= 00000001#", 2'b00, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk("^1@0000300: $1 <= 00000001#", 2'b00, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk("^1@00003000: $1 < = 00000001#", 2'b00, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk("^1@00003000: $00031 <= 00000001#", 2'b00, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk("garbage^1@00003000: $1 <= 0000000g#", 2'b00, 2'b00, 0, 0, 0, 0));

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ft_a",  32'(bus_a.format_type), 32'd0);
    chk("rst_time",  bus_a.time_val, 32'd0);
    chk("rst_pc",    bus_a.pc_val,   32'd0);
    chk("rst_idx",   bus_a.idx_val,  32'd0);
    chk("rst_data",  bus_a.data_val, 32'd0);
    chk("rst_ok",    32'(bus_a.ok_count),  32'd0);
    chk("rst_err",   32'(bus_a.err_count), 32'd0);
    chk("rst_ft_b",  32'(bus_b.format_type), 32'd0);

    foreach (vecs[k]) send_line(vecs[k]);
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("hold_time", bus_a.time_val, last_t);
    chk("hold_pc",   bus_a.pc_val,   last_pc);
    chk("hold_idx",  bus_a.idx_val,  last_idx);
    chk("hold_data", bus_a.data_val, last_data);
    chk("hold_ok_a",  32'(bus_a.ok_count),  32'(exp_ok_a));
    chk("hold_err_a", 32'(bus_a.err_count), 32'(exp_err_a));

    // Reset while data is one digit short: the completing "1#" must not report.
    send_raw("^1@00003000: $1 <= 0000000");
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    exp_ok_a = 0; exp_err_a = 0; exp_ok_b = 0; exp_err_b = 0;
    send_raw("1#");
    repeat (3) @(negedge clk);
    chk("midrst_ok",   32'(bus_a.ok_count), 32'd0);
    chk("midrst_time", bus_a.time_val,      32'd0);
    chk("midrst_ft",   32'(bus_a.format_type), 32'd0);

    // Saturation: preload just below the ceiling, then two back-to-back lines.
    @(negedge clk);
    force dut.ok_count_reg = 16'hFFFE;
    @(negedge clk);
    release dut.ok_count_reg;
    exp_ok_a = 16'hFFFE;
    send_line(vecs[0]);
    send_line(vecs[0]);
    repeat (4) @(negedge clk);
    chk("sat_ok_a", 32'(bus_a.ok_count), 32'h0000FFFF);
    chk("sat_ok_b", 32'(bus_b.ok_count), 32'd2);
    chk("sb_final", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
